// File: rtl/soc_bus_pkg.sv
// Shared bus constants and FSM encoding for the core-to-peripheral memory bus.
package soc_bus_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } bus_state_t;

    // Index width that stays legal (>= 1 bit) for a single slave or a disabled timer.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mem_addr_decode.sv
// Combinational priority address decoder: lowest matching slave index wins.
module mem_addr_decode
    import soc_bus_pkg::*;
#(
    parameter int NSLAVES = 3,
    parameter int SEL_W = 2,
    parameter logic [ADDR_W*NSLAVES-1:0] BASE = '0,
    parameter logic [ADDR_W*NSLAVES-1:0] MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [SEL_W-1:0]  sel
);
    always_comb begin
        hit = 1'b0;
        sel = '0;
        // Walk downwards so the lowest matching index is the last one written.
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if ((addr & MASK[ADDR_W*i +: ADDR_W]) == BASE[ADDR_W*i +: ADDR_W]) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end
endmodule

// File: rtl/mem_bus_mux.sv
// 1-master/N-slave memory-bus interconnect: registered slave select, gated
// per-slave strobes, unmapped-address error response and wait-state watchdog.
//
//  state   | meaning
//  IDLE    | no transfer; decode a new request from the master
//  WAIT    | request forwarded to slave sel; waiting for its ready or the watchdog
//  ERR     | one-cycle error response for an unmapped address
module mem_bus_mux
    import soc_bus_pkg::*;
#(
    parameter int NSLAVES = 3,
    parameter logic [32*NSLAVES-1:0] SLAVE_BASE = {32'h02000000, 32'h00001000, 32'h00000000},
    parameter logic [32*NSLAVES-1:0] SLAVE_MASK = {32'hFFFFFFFF, 32'hFF000000, 32'hFFFFF000},
    parameter int TIMEOUT = 255,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       m_valid,
    output logic                       m_ready,
    input  logic [ADDR_W-1:0]          m_addr,
    input  logic [DATA_W-1:0]          m_wdata,
    input  logic [STRB_W-1:0]          m_wstrb,
    output logic [DATA_W-1:0]          m_rdata,
    output logic                       m_err,
    output logic [NSLAVES-1:0]         s_valid,
    input  logic [NSLAVES-1:0]         s_ready,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    output logic [STRB_W*NSLAVES-1:0]  s_wstrb,
    input  logic [DATA_W*NSLAVES-1:0]  s_rdata
);
    localparam int SEL_W = idx_width(NSLAVES);
    localparam int TMR_W = idx_width(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    bus_state_t       state;
    logic [SEL_W-1:0] sel;
    logic [TMR_W-1:0] timer;
    logic             dec_hit;
    logic [SEL_W-1:0] dec_sel;
    logic             wait_act;
    logic             sel_ready;
    logic             tmo_hit;
    logic             wait_done;
    logic             wait_tmo;

    mem_addr_decode #(
        .NSLAVES (NSLAVES),
        .SEL_W   (SEL_W),
        .BASE    (SLAVE_BASE),
        .MASK    (SLAVE_MASK)
    ) u_decode (
        .addr (m_addr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
            sel   <= '0;
            timer <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m_valid) begin
                        if (dec_hit) begin
                            sel   <= dec_sel;
                            timer <= '0;
                            state <= ST_WAIT;
                        end else begin
                            state <= ST_ERR;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!m_valid || sel_ready || tmo_hit) begin
                        state <= ST_IDLE;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign s_addr  = m_addr;
    assign s_wdata = m_wdata;

    always_comb begin
        wait_act  = (state == ST_WAIT) && m_valid;
        sel_ready = s_ready[sel];
        tmo_hit   = (TIMEOUT != 0) && (timer == TMR_LAST);
        wait_done = wait_act && sel_ready;
        wait_tmo  = wait_act && !sel_ready && tmo_hit;

        s_valid = '0;
        s_wstrb = '0;
        if (wait_act && !wait_tmo) begin
            s_valid[sel]                    = 1'b1;
            s_wstrb[STRB_W*sel +: STRB_W]   = m_wstrb;
        end

        // Responses are suppressed while reset is asserted so an interrupted transfer never completes.
        m_ready = resetn && (wait_done || wait_tmo || (state == ST_ERR));
        m_err   = resetn && (wait_tmo || (state == ST_ERR));
        m_rdata = (resetn && wait_done) ? s_rdata[DATA_W*sel +: DATA_W] : ERR_RDATA;
    end
endmodule

// File: tb/tb_mem_bus_mux.sv
// Directed bench for mem_bus_mux: per-cycle expectations built from the bus
// rules, compared against the DUT on every falling edge.
module tb_mem_bus_mux;
    localparam int NS  = 3;
    localparam int TMO = 4;
    localparam logic [95:0] BASE = {32'h02000000, 32'h00000000, 32'h00000000};
    localparam logic [95:0] MASK = {32'hFF000000, 32'hFF000000, 32'hFFFFF000};
    localparam logic [31:0] ERRD = 32'h00000000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        m_err;
    logic [2:0]  s_valid;
    logic [2:0]  s_ready;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [11:0] s_wstrb;
    logic [95:0] s_rdata;

    logic [31:0] sdata [NS];

    always #5 clk = ~clk;

    mem_bus_mux #(
        .NSLAVES    (NS),
        .SLAVE_BASE (BASE),
        .SLAVE_MASK (MASK),
        .TIMEOUT    (TMO),
        .ERR_RDATA  (ERRD)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_rdata (m_rdata),
        .m_err   (m_err),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_rdata (s_rdata)
    );

    typedef struct {
        logic        m_ready;
        logic        m_err;
        logic [31:0] m_rdata;
        logic [2:0]  s_valid;
        logic [11:0] s_wstrb;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int exp_slave(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & MASK[32*i +: 32]) == BASE[32*i +: 32]) return i;
        return -1;
    endfunction

    function automatic exp_t quiet();
        exp_t e;
        e.m_ready = 1'b0;
        e.m_err   = 1'b0;
        e.m_rdata = ERRD;
        e.s_valid = 3'b000;
        e.s_wstrb = 12'h000;
        e.s_addr  = m_addr;
        e.s_wdata = m_wdata;
        return e;
    endfunction

    initial begin : cmp
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("m_ready", 64'(m_ready), 64'(e.m_ready));
                chk("m_err",   64'(m_err),   64'(e.m_err));
                chk("m_rdata", 64'(m_rdata), 64'(e.m_rdata));
                chk("s_valid", 64'(s_valid), 64'(e.s_valid));
                chk("s_wstrb", 64'(s_wstrb), 64'(e.s_wstrb));
                chk("s_addr",  64'(s_addr),  64'(e.s_addr));
                chk("s_wdata", 64'(s_wdata), 64'(e.s_wdata));
            end
        end
    end

    task automatic idle_cycle();
        @(posedge clk); #1;
        resetn  = 1'b1;
        m_valid = 1'b0;
        s_ready = 3'b000;
        exp_q.push_back(quiet());
    endtask

    // ready_at: wait cycle where the target asserts ready (0 = never).
    // abort_at / reset_at: wait cycle where the master drops m_valid / reset is pulsed (0 = none).
    task automatic txn(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                       input int ready_at, input bit other_rdy, input int abort_at, input int reset_at);
        int   slv;
        bit   done;
        exp_t e;
        slv = exp_slave(addr);
        @(posedge clk); #1;
        resetn  = 1'b1;
        m_valid = 1'b1;
        m_addr  = addr;
        m_wdata = wdata;
        m_wstrb = wstrb;
        s_ready = other_rdy ? 3'b111 : 3'b000;
        exp_q.push_back(quiet());
        if (slv < 0) begin
            @(posedge clk); #1;
            e = quiet();
            e.m_ready = 1'b1;
            e.m_err   = 1'b1;
            exp_q.push_back(e);
        end else begin
            done = 1'b0;
            for (int k = 1; k <= 12 && !done; k++) begin
                @(posedge clk); #1;
                s_ready      = other_rdy ? 3'b111 : 3'b000;
                s_ready[slv] = (ready_at > 0) && (k >= ready_at);
                e = quiet();
                if (k == abort_at) begin
                    m_valid = 1'b0;
                    done    = 1'b1;
                end else if (k == reset_at) begin
                    resetn       = 1'b0;
                    s_ready[slv] = 1'b0;
                    e.s_valid    = 3'b001 << slv;
                    e.s_wstrb    = 12'(wstrb) << (4 * slv);
                    done         = 1'b1;
                end else if (s_ready[slv]) begin
                    e.s_valid = 3'b001 << slv;
                    e.s_wstrb = 12'(wstrb) << (4 * slv);
                    e.m_ready = 1'b1;
                    e.m_rdata = sdata[slv];
                    done      = 1'b1;
                end else if (k == TMO) begin
                    e.m_ready = 1'b1;
                    e.m_err   = 1'b1;
                    done      = 1'b1;
                end else begin
                    e.s_valid = 3'b001 << slv;
                    e.s_wstrb = 12'(wstrb) << (4 * slv);
                end
                exp_q.push_back(e);
            end
        end
    endtask

    initial begin
        sdata[0] = 32'h12345678;
        sdata[1] = 32'hA5A50001;
        sdata[2] = 32'hDEADBEEF;
        s_rdata  = {sdata[2], sdata[1], sdata[0]};
        resetn   = 1'b0;
        m_valid  = 1'b0;
        m_addr   = 32'h0;
        m_wdata  = 32'h0;
        m_wstrb  = 4'h0;
        s_ready  = 3'b000;

        // Pin the decode model against hand-derived slave indices.
        chk("model_dec_overlap",  64'(exp_slave(32'h00000010)), 64'(0));
        chk("model_dec_slave1",   64'(exp_slave(32'h00002000)), 64'(1));
        chk("model_dec_slave2",   64'(exp_slave(32'h02000000)), 64'(2));
        chk("model_dec_unmapped", 64'(exp_slave(32'h03000000)), 64'(-1));

        @(posedge clk); #1;
        exp_q.push_back(quiet());
        @(posedge clk); #1;
        exp_q.push_back(quiet());

        // Zero-wait read from slave 0, all readies tied high.
        txn(32'h00000000, 4'h0, 32'h0, 1, 1'b1, 0, 0);
        @(negedge clk); #1;
        chk("t1_rdata_lit",  64'(m_rdata), 64'h12345678);
        chk("t1_svalid_lit", 64'(s_valid), 64'h1);

        // Write to slave 2 with two wait states; other readies high must be ignored.
        txn(32'h02000000, 4'hF, 32'hCAFEF00D, 3, 1'b1, 0, 0);
        @(negedge clk); #1;
        chk("t2_wstrb_lit", 64'(s_wstrb), 64'hF00);

        // Unmapped read.
        txn(32'h03000000, 4'h0, 32'h0, 0, 1'b0, 0, 0);
        @(negedge clk); #1;
        chk("t3_err_lit",   64'({m_ready, m_err}), 64'h3);
        chk("t3_rdata_lit", 64'(m_rdata), 64'h0);

        // Slave 1 never ready: watchdog fires on wait cycle 4.
        txn(32'h00002000, 4'h0, 32'h0, 0, 1'b0, 0, 0);
        @(negedge clk); #1;
        chk("t4_tmo_lit",    64'({m_ready, m_err}), 64'h3);
        chk("t4_svalid_lit", 64'(s_valid), 64'h0);

        // Overlapping map: address hits slaves 0 and 1, slave 0 must win.
        txn(32'h00000010, 4'b0011, 32'h00005A5A, 2, 1'b0, 0, 0);
        @(negedge clk); #1;
        chk("t5_svalid_lit", 64'(s_valid), 64'h1);

        // Reset in the middle of a 3-wait-state access to slave 1, then a normal access.
        txn(32'h00100000, 4'h0, 32'h0, 4, 1'b0, 0, 2);
        idle_cycle();
        txn(32'h00100000, 4'h0, 32'h0, 2, 1'b0, 0, 0);

        // Master abort on slave 2, then a zero-wait retry.
        txn(32'h02000000, 4'h0, 32'h0, 0, 1'b0, 2, 0);
        txn(32'h02000000, 4'h0, 32'h0, 1, 1'b0, 0, 0);

        // Ready arrives on the same cycle the watchdog would fire: ready wins.
        txn(32'h00003000, 4'hC, 32'h11223344, TMO, 1'b0, 0, 0);
        @(negedge clk); #1;
        chk("t8_race_lit", 64'({m_ready, m_err}), 64'h2);

        idle_cycle();
        idle_cycle();
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
